// File: rtl/jt10_adpcma_pkg.sv
// Shared constants and helpers for the time-multiplexed ADPCM-A decoder.
// Output saturation is enabled by defining JT10_ADPCMA_SAT_EN.
package jt10_adpcma_pkg;

  localparam int unsigned STEPW      = 6;
  localparam int unsigned STEP_MAX   = 48;
  localparam int          STEP_DEC   = -1;
  localparam int          STEP_INC4  = 2;
  localparam int          STEP_INC5  = 5;
  localparam int          STEP_INC6  = 7;
  localparam int          STEP_INC7  = 9;
  localparam int unsigned NUM_STAGES = 4;
  localparam int unsigned LUT_AW     = STEPW + 3;
  localparam int unsigned LUT_DW     = 12;

  // Step index adaptation from nibble magnitude, clamped to [0, STEP_MAX]
  function automatic logic [STEPW-1:0] step_next(input logic [STEPW-1:0] step,
                                                 input logic [2:0]       mag);
    int s;
    case (mag)
      3'd4:    s = int'(step) + STEP_INC4;
      3'd5:    s = int'(step) + STEP_INC5;
      3'd6:    s = int'(step) + STEP_INC6;
      3'd7:    s = int'(step) + STEP_INC7;
      default: s = int'(step) + STEP_DEC;
    endcase
    if (s < 0) s = 0;
    else if (s > int'(STEP_MAX)) s = int'(STEP_MAX);
    return STEPW'(s);
  endfunction

  // Clamp a sign-extended sum to the signed range of a sigw-bit accumulator
  function automatic logic signed [16:0] saturate(input logic signed [16:0] v,
                                                  input int unsigned        sigw);
    logic signed [16:0] hi;
    logic signed [16:0] lo;
    hi = (17'sd1 <<< (sigw - 1)) - 17'sd1;
    lo = -hi - 17'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/jt10_adpcma_lut.sv
// ADPCM-A increment ROM: entry = (2*mag+1)*step_size/8, registered output.
module jt10_adpcma_lut
  import jt10_adpcma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen_i,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [LUT_DW-1:0] inc_o
);

  function automatic logic [11:0] step_size(input logic [STEPW-1:0] s);
    case (s)
      6'd0:  return 12'd16;   6'd1:  return 12'd17;   6'd2:  return 12'd19;
      6'd3:  return 12'd21;   6'd4:  return 12'd23;   6'd5:  return 12'd25;
      6'd6:  return 12'd28;   6'd7:  return 12'd31;   6'd8:  return 12'd34;
      6'd9:  return 12'd37;   6'd10: return 12'd41;   6'd11: return 12'd45;
      6'd12: return 12'd50;   6'd13: return 12'd55;   6'd14: return 12'd60;
      6'd15: return 12'd66;   6'd16: return 12'd73;   6'd17: return 12'd80;
      6'd18: return 12'd88;   6'd19: return 12'd97;   6'd20: return 12'd107;
      6'd21: return 12'd118;  6'd22: return 12'd130;  6'd23: return 12'd143;
      6'd24: return 12'd157;  6'd25: return 12'd173;  6'd26: return 12'd190;
      6'd27: return 12'd209;  6'd28: return 12'd230;  6'd29: return 12'd253;
      6'd30: return 12'd279;  6'd31: return 12'd307;  6'd32: return 12'd337;
      6'd33: return 12'd371;  6'd34: return 12'd408;  6'd35: return 12'd449;
      6'd36: return 12'd494;  6'd37: return 12'd544;  6'd38: return 12'd598;
      6'd39: return 12'd658;  6'd40: return 12'd724;  6'd41: return 12'd796;
      6'd42: return 12'd876;  6'd43: return 12'd963;  6'd44: return 12'd1060;
      6'd45: return 12'd1166; 6'd46: return 12'd1282; 6'd47: return 12'd1411;
      6'd48: return 12'd1552;
      default: return 12'd0;
    endcase
  endfunction

  logic [LUT_DW-1:0] inc_d;
  int unsigned       prod;

  always_comb begin
    prod  = 0;
    inc_d = '0;
    prod  = (2 * int'(addr_i[2:0]) + 1) * int'(step_size(addr_i[LUT_AW-1:3]));
    inc_d = LUT_DW'(prod >> 3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     inc_o <= '0;
    else if (cen_i) inc_o <= inc_d;
  end

endmodule

// File: rtl/jt10_adpcma_mch.sv
// CH-channel time-multiplexed ADPCM-A decoder; channel state circulates in a
// depth-CH register ring. Define JT10_ADPCMA_SAT_EN to saturate instead of wrap.
module jt10_adpcma_mch
  import jt10_adpcma_pkg::*;
#(
  parameter int unsigned CH   = 6,
  parameter int unsigned SIGW = 15,
  parameter int unsigned CHW  = $clog2(CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic [3:0]         data,
  input  logic               chon,
  input  logic               kon,
  output logic [CHW-1:0]     ch_cur,
  output logic signed [15:0] pcm,
  output logic [CHW-1:0]     pcm_ch,
  output logic               pcm_vld
);

  localparam int unsigned    DLY     = CH - NUM_STAGES;
  localparam logic [CHW-1:0] CH_LAST = CHW'(CH - 1);

  logic [CHW-1:0]         ch_q, ch_d;
  logic signed [SIGW-1:0] head_x;
  logic [STEPW-1:0]       head_step;

  logic [LUT_AW-1:0]      s1_addr_q, s1_addr_d;
  logic                   s1_sign_q, s1_on_q;
  logic [STEPW-1:0]       s1_step_q, s1_step_d;
  logic signed [SIGW-1:0] s1_x_q, s1_x_d;
  logic [CHW-1:0]         s1_ch_q;

  logic                   s2_sign_q, s2_on_q;
  logic [STEPW-1:0]       s2_step_q;
  logic signed [SIGW-1:0] s2_x_q;
  logic [CHW-1:0]         s2_ch_q;
  logic [LUT_DW-1:0]      lut_inc;

  logic signed [SIGW-1:0] s3_inc_q, s3_inc_d, inc_abs;
  logic                   s3_on_q;
  logic [STEPW-1:0]       s3_step_q;
  logic signed [SIGW-1:0] s3_x_q;
  logic [CHW-1:0]         s3_ch_q;

  logic signed [SIGW-1:0] s4_x_q, s4_x_d, x_sum;
  logic [STEPW-1:0]       s4_step_q;
  logic                   s4_on_q;
  logic [CHW-1:0]         s4_ch_q;
`ifdef JT10_ADPCMA_SAT_EN
  logic signed [SIGW:0]   sum_w;
`endif

  // Stage I: ring head with key-on clear, step adaptation; III/IV arithmetic
  always_comb begin
    logic [STEPW-1:0] step_cur;
    ch_d      = (ch_q == CH_LAST) ? '0 : ch_q + CHW'(1);
    step_cur  = kon ? '0 : head_step;
    s1_x_d    = kon ? '0 : head_x;
    s1_addr_d = {step_cur, data[2:0]};
    s1_step_d = chon ? step_next(step_cur, data[2:0]) : step_cur;
    inc_abs   = SIGW'(lut_inc);
    s3_inc_d  = s2_sign_q ? -inc_abs : inc_abs;
`ifdef JT10_ADPCMA_SAT_EN
    sum_w     = {s3_x_q[SIGW-1], s3_x_q} + {s3_inc_q[SIGW-1], s3_inc_q};
    x_sum     = SIGW'(saturate(17'(sum_w), SIGW));
`else
    x_sum     = s3_x_q + s3_inc_q;
`endif
    s4_x_d    = s3_on_q ? x_sum : s3_x_q;
  end

  jt10_adpcma_lut u_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen_i  (cen),
    .addr_i (s1_addr_q),
    .inc_o  (lut_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q      <= '0;
      s1_addr_q <= '0; s1_sign_q <= 1'b0; s1_on_q <= 1'b0;
      s1_step_q <= '0; s1_x_q    <= '0;   s1_ch_q <= '0;
      s2_sign_q <= 1'b0; s2_on_q <= 1'b0; s2_step_q <= '0;
      s2_x_q    <= '0;   s2_ch_q <= '0;
      s3_inc_q  <= '0;   s3_on_q <= 1'b0; s3_step_q <= '0;
      s3_x_q    <= '0;   s3_ch_q <= '0;
      s4_x_q    <= '0;   s4_step_q <= '0; s4_on_q <= 1'b0;
      s4_ch_q   <= '0;
    end else if (cen) begin
      ch_q      <= ch_d;
      s1_addr_q <= s1_addr_d; s1_sign_q <= data[3]; s1_on_q <= chon;
      s1_step_q <= s1_step_d; s1_x_q    <= s1_x_d;  s1_ch_q <= ch_q;
      s2_sign_q <= s1_sign_q; s2_on_q <= s1_on_q;   s2_step_q <= s1_step_q;
      s2_x_q    <= s1_x_q;    s2_ch_q <= s1_ch_q;
      s3_inc_q  <= s3_inc_d;  s3_on_q <= s2_on_q;   s3_step_q <= s2_step_q;
      s3_x_q    <= s2_x_q;    s3_ch_q <= s2_ch_q;
      s4_x_q    <= s4_x_d;    s4_step_q <= s3_step_q; s4_on_q <= s3_on_q;
      s4_ch_q   <= s3_ch_q;
    end
  end

  // Remaining ring depth so a channel's result returns exactly CH slots later
  if (DLY == 0) begin : g_nodly
    assign head_x    = s4_x_q;
    assign head_step = s4_step_q;
  end else begin : g_dly
    logic signed [SIGW-1:0] dx_q [DLY];
    logic [STEPW-1:0]       ds_q [DLY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DLY); i++) begin
          dx_q[i] <= '0;
          ds_q[i] <= '0;
        end
      end else if (cen) begin
        dx_q[0] <= s4_x_q;
        ds_q[0] <= s4_step_q;
        for (int i = 1; i < int'(DLY); i++) begin
          dx_q[i] <= dx_q[i-1];
          ds_q[i] <= ds_q[i-1];
        end
      end
    end

    assign head_x    = dx_q[DLY-1];
    assign head_step = ds_q[DLY-1];
  end

  assign ch_cur  = ch_q;
  assign pcm     = 16'(s4_x_q);
  assign pcm_ch  = s4_ch_q;
  assign pcm_vld = s4_on_q;

endmodule

// File: tb/tb_jt10_adpcma_mch.sv
// Directed bench for jt10_adpcma_mch (CH=6, SIGW=15); expected values worked by hand.
module tb_jt10_adpcma_mch;

  localparam int unsigned CHW = 3;
`ifdef JT10_ADPCMA_SAT_EN
  localparam int SAT_EXP = 16383;
`else
  localparam int SAT_EXP = -14451;
`endif

  logic               clk = 1'b0;
  logic               rst_n, cen, chon, kon;
  logic [3:0]         data;
  logic [CHW-1:0]     ch_cur, pcm_ch;
  logic signed [15:0] pcm;
  logic               pcm_vld;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jt10_adpcma_mch #(.CH(6), .SIGW(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .data    (data),
    .chon    (chon),
    .kon     (kon),
    .ch_cur  (ch_cur),
    .pcm     (pcm),
    .pcm_ch  (pcm_ch),
    .pcm_vld (pcm_vld)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic slot(input logic c, input logic k, input logic [3:0] d);
    @(negedge clk);
    cen  = 1'b1;
    chon = c;
    kon  = k;
    data = d;
    @(posedge clk);
  endtask

  task automatic out(input string tag, input int p, input int ch, input logic v);
    #1;
    chk({tag, ".pcm"}, pcm, 16'(p));
    chk({tag, ".ch"},  16'(pcm_ch), 16'(ch));
    chk({tag, ".vld"}, 16'(pcm_vld), 16'(v));
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b0; chon = 1'b0; kon = 1'b0; data = 4'd0;
    #3;
    chk("reset.ch_cur", 16'(ch_cur), 16'd0);
    chk("reset.pcm", pcm, 16'd0);
    chk("reset.pcm_ch", 16'(pcm_ch), 16'd0);
    chk("reset.vld", 16'(pcm_vld), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Round 1
    slot(1, 0, 4'b0000);
    slot(1, 0, 4'b1000);
    slot(1, 0, 4'b0111);
    slot(1, 0, 4'b0000); out("r1c0", 2, 0, 1);
    slot(0, 0, 4'b0000); out("r1c1", -2, 1, 1);
    slot(0, 0, 4'b0000); out("r1c2", 30, 2, 1);
    // Round 2
    slot(1, 0, 4'b0000); out("r1c3", 2, 3, 1);
    slot(0, 0, 4'b0000); out("r1c4", 0, 4, 0);
    slot(1, 0, 4'b0000); out("r1c5", 0, 5, 0);
    slot(0, 0, 4'b0000); out("r2c0", 4, 0, 1);
    slot(0, 0, 4'b0000); out("r2c1", -2, 1, 0);
    slot(0, 0, 4'b0000); out("r2c2_step9", 34, 2, 1);
    // Round 3
    slot(1, 0, 4'b0000); out("r2c3_off", 2, 3, 0);
    slot(0, 0, 4'b0000);
    slot(0, 0, 4'b0000);
    slot(1, 0, 4'b0000); out("r3c0", 6, 0, 1);
    slot(0, 0, 4'b0000);
    slot(0, 0, 4'b0000); out("r3c2", 34, 2, 0);
    // Round 4: key-on on channels 0, 2 and 3
    slot(1, 1, 4'b0000); out("r3c3_held", 4, 3, 1);
    slot(0, 0, 4'b0000);
    slot(1, 1, 4'b0111);
    slot(0, 1, 4'b0000); out("r4c0_kon", 2, 0, 1);
    slot(0, 0, 4'b0000);
    slot(0, 0, 4'b0000); out("r4c2_kon", 30, 2, 1);
    // Round 5
    slot(1, 0, 4'b0000); out("r4c3_kon_off", 0, 3, 0);
    slot(0, 0, 4'b0000);
    slot(1, 0, 4'b0000);
    slot(0, 0, 4'b0000); out("r5c0", 4, 0, 1);
    slot(0, 0, 4'b0000);
    slot(0, 0, 4'b0000); out("r5c2_step_restart", 34, 2, 1);

    // Clock enable low: nothing moves
    @(negedge clk);
    cen = 1'b0; chon = 1'b1; kon = 1'b1; data = 4'b0111;
    repeat (3) @(posedge clk);
    out("cen_hold", 34, 2, 1);
    chk("cen_hold.ch_cur", 16'(ch_cur), 16'd0);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    out("rst_mid", 0, 0, 0);
    chk("rst_mid.ch_cur", 16'(ch_cur), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Repeated 0111 on channel 5 drives the accumulator past full scale
    for (int r = 0; r < 12; r++) begin
      for (int s = 0; s < 6; s++) begin
        slot((s == 5 && r < 11) || (s == 0 && r == 0), 1'b0, (s == 5) ? 4'b0111 : 4'b0000);
        if (r == 0 && s == 2) out("rst_vld3", 0, 0, 0);
        if (r == 0 && s == 3) begin
          out("rst_vld4", 2, 0, 1);
          chk("rst_vld4.ch_cur", 16'(ch_cur), 16'd4);
        end
        if (r == 1 && s == 2)  out("sat_r1", 30, 5, 1);
        if (r == 10 && s == 2) out("sat_r10", 15407, 5, 1);
        if (r == 11 && s == 2) out("sat_r11", SAT_EXP, 5, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
